// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream from the UART receiver plus the instruction memory write port.
interface imem_loader_if #(
  parameter int ADDRESS_WIDTH = 14
);
  logic                     rx_valid;
  logic [7:0]               rx_data;
  logic                     rx_ready;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [7:0]               mem_wdata;

  // master is the loader: it sinks the byte stream and drives the memory write side.
  modport master (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/loader_gap_timer.sv
// Counts idle cycles between accepted bytes; expired holds once the limit is reached.
module loader_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned LIMIT = TIMEOUT_CYCLES - 1;
  localparam int          W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != W'(LIMIT))) begin
      count <= count + W'(1);
    end
  end

  assign expired = enable && (count == W'(LIMIT));

endmodule

// File: rtl/imem_loader.sv
// Parses the framed boot image, writes payload bytes from address 0 and
// releases the core reset only after a checksum-clean load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 14,
  parameter int DEPTH          = 16384,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.master bus,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err_code
);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [14:0] index;
  logic [7:0]  sum;

  logic        accept;
  logic        in_frame;
  logic        gap_expired;
  logic [15:0] len_rx;
  logic        len_bad;
  logic        last_byte;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign in_frame  = state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM};
  assign len_rx    = {len_hi, bus.rx_data};
  assign len_bad   = (len_rx == 16'd0) || ({1'b0, len_rx} > 17'(DEPTH));
  assign last_byte = (({1'b0, index} + 16'd1) == len);

  // Any accepted byte restarts the gap count, so a byte arriving on the expiry cycle wins.
  loader_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept || !in_frame),
    .enable  (in_frame),
    .expired (gap_expired)
  );

  // NOTE: every register here, state and outputs alike, uses <= so all of them
  // update together from the values sampled at the same clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      len_hi        <= '0;
      len           <= '0;
      index         <= '0;
      sum           <= '0;
      bus.rx_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_rst_n     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      bus.rx_ready <= 1'b1;
      bus.mem_we   <= 1'b0;
      if (accept) begin
        unique case (state)
          ST_IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state <= ST_LEN_HI;
              busy  <= 1'b1;
            end
          end
          ST_LEN_HI: begin
            len_hi <= bus.rx_data;
            state  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            if (len_bad) begin
              state    <= ST_ERROR;
              err_code <= ERR_LEN;
              busy     <= 1'b0;
            end else begin
              len   <= len_rx;
              index <= '0;
              sum   <= '0;
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= index[ADDRESS_WIDTH-1:0];
            bus.mem_wdata <= bus.rx_data;
            sum           <= sum + bus.rx_data;
            index         <= index + 15'd1;
            if (last_byte) state <= ST_CSUM;
          end
          ST_CSUM: begin
            busy <= 1'b0;
            if (bus.rx_data == sum) begin
              state     <= ST_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state    <= ST_ERROR;
              err_code <= ERR_CSUM;
            end
          end
          ST_DONE, ST_ERROR: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state     <= ST_LEN_HI;
              busy      <= 1'b1;
              done      <= 1'b0;
              cpu_rst_n <= 1'b0;
              err_code  <= ERR_NONE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (gap_expired) begin
        state    <= ST_ERROR;
        err_code <= ERR_TIMEOUT;
        busy     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized frames against a byte-queue model of the boot loader.
module tb_imem_loader;

  localparam int AW    = 14;
  localparam int DEPTH = 16384;
  localparam int TO    = 40;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic [1:0] err_code;

  imem_loader_if #(.ADDRESS_WIDTH(AW)) bus ();

  imem_loader #(
    .ADDRESS_WIDTH (AW),
    .DEPTH         (DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [AW+7:0] got_q[$];
  int            got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_q.push_back({bus.mem_addr, bus.mem_wdata});
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t rand_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  function automatic logic [7:0] sum8(input bq_t pl);
    int s = 0;
    foreach (pl[i]) s = s + int'(pl[i]);
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " rx_ready"},  bus.rx_ready,  0);
    chk({tag, " mem_we"},    bus.mem_we,    0);
    chk({tag, " mem_addr"},  bus.mem_addr,  0);
    chk({tag, " mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, " cpu_rst_n"}, cpu_rst_n,     0);
    chk({tag, " busy"},      busy,          0);
    chk({tag, " done"},      done,          0);
    chk({tag, " err_code"},  err_code,      0);
  endtask

  // Payload bytes land at 0..n-1 in order; optionally one write per consecutive cycle.
  task automatic check_writes(input string tag, input bq_t pl, input bit b2b);
    chk({tag, " write count"}, got_q.size(), pl.size());
    if (got_q.size() == pl.size()) begin
      foreach (pl[i]) begin
        chk($sformatf("%s write %0d", tag, i), got_q[i], {AW'(i), pl[i]});
        if (b2b) chk($sformatf("%s write cycle %0d", tag, i), got_cyc[i], got_cyc[0] + i);
      end
    end
  endtask

  task automatic start_frame(input string tag, input logic [15:0] n);
    got_q.delete();
    got_cyc.delete();
    send_byte(8'hA5);
    chk({tag, " sync busy"}, busy, 1);
    chk({tag, " sync done"}, done, 0);
    chk({tag, " sync cpu_rst_n"}, cpu_rst_n, 0);
    chk({tag, " sync err"}, err_code, 0);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic finish_frame(input string tag, input logic [7:0] csum, input logic [1:0] exp_err);
    chk({tag, " pre-csum busy"}, busy, 1);
    chk({tag, " pre-csum done"}, done, 0);
    send_byte(csum);
    chk({tag, " done"}, done, (exp_err == 2'd0));
    chk({tag, " cpu_rst_n"}, cpu_rst_n, (exp_err == 2'd0));
    chk({tag, " err_code"}, err_code, exp_err);
    chk({tag, " busy"}, busy, 0);
  endtask

  task automatic send_frame(input string tag, input bq_t pl, input logic [7:0] csum,
                            input logic [1:0] exp_err);
    start_frame(tag, 16'(pl.size()));
    foreach (pl[i]) send_byte(pl[i]);
    finish_frame(tag, csum, exp_err);
    check_writes(tag, pl, 1'b1);
  endtask

  initial begin
    bq_t pl;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset values, then rx_ready rises on the first edge after release.
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rx_ready before edge", bus.rx_ready, 0);
    @(posedge clk);
    #1;
    chk("rx_ready after edge", bus.rx_ready, 1);

    // Known-good frame.
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame("good", pl, 8'hAA, 2'd0);

    // Same payload, bad checksum: writes still happen, then checksum error.
    send_frame("badcsum", pl, 8'hAB, 2'd2);

    // Zero and over-depth lengths are rejected before any write.
    start_frame("len0", 16'h0000);
    chk("len0 err", err_code, 1);
    chk("len0 busy", busy, 0);
    chk("len0 writes", got_q.size(), 0);
    start_frame("len4001", 16'h4001);
    chk("len4001 err", err_code, 1);
    chk("len4001 done", done, 0);
    chk("len4001 writes", got_q.size(), 0);

    // Garbage is discarded, then a random frame loads.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    chk("garbage err kept", err_code, 1);
    chk("garbage busy", busy, 0);
    pl = rand_payload($urandom_range(1, 16));
    send_frame("after garbage", pl, sum8(pl), 2'd0);

    // Stall after payload byte 2: error appears TO cycles after its accept.
    pl = rand_payload(5);
    start_frame("timeout", 16'd5);
    for (int i = 0; i < 3; i++) send_byte(pl[i]);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("timeout not yet err", err_code, 0);
    chk("timeout not yet busy", busy, 1);
    @(posedge clk);
    #1;
    chk("timeout err", err_code, 3);
    chk("timeout busy", busy, 0);
    chk("timeout done", done, 0);
    check_writes("timeout", pl[0:2], 1'b1);

    pl = rand_payload($urandom_range(1, 16));
    send_frame("after timeout", pl, sum8(pl), 2'd0);

    // A byte arriving on the expiry cycle keeps the frame alive.
    pl = rand_payload(3);
    start_frame("edge gap", 16'd3);
    send_byte(pl[0]);
    repeat (TO - 1) @(posedge clk);
    send_byte(pl[1]);
    chk("edge gap err", err_code, 0);
    send_byte(pl[2]);
    finish_frame("edge gap", sum8(pl), 2'd0);
    check_writes("edge gap", pl, 1'b0);

    // Asynchronous reset mid-DATA, then a clean reload.
    pl = rand_payload(8);
    start_frame("midreset", 16'd8);
    for (int i = 0; i < 3; i++) send_byte(pl[i]);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pl = rand_payload($urandom_range(4, 20));
    send_frame("after reset", pl, sum8(pl), 2'd0);

    // Largest legal image fills the whole memory.
    pl = rand_payload(DEPTH);
    send_frame("full depth", pl, sum8(pl), 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
